// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and pipeline entry type
// for the 64-point DIF FFT twiddle sequencer.
package fft_pkg;

    localparam int FFT_N = 64;
    localparam int LOG2N = 6;
    localparam int NBFLY = 32;
    localparam int TW_W  = 5;

    localparam logic [TW_W-1:0] E_NEGJ = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic            vld;
        logic [TW_W-1:0] e;
        logic            one;
        logic            negj;
        logic            s5;
        logic            last;
    } tw_ent_t;

    // Twiddle exponent of butterfly b in stage s: keep the
    // low (5-s) index bits and scale them up by 2^s.
    function automatic logic [TW_W-1:0] tw_exp(
        input logic [2:0]      s,
        input logic [TW_W-1:0] b
    );
        logic [TW_W-1:0] j;
        j = b & 5'((6'd32 >> s) - 6'd1);
        return 5'(j << s);
    endfunction

endpackage

// File: rtl/fft_twiddle_sched_if.sv
// Control/twiddle bundle between the frame controller and
// the twiddle sequencer.
interface fft_twiddle_sched_if;

    logic       start;
    logic       valid;
    logic       abort;
    logic       busy;
    logic [2:0] stage;
    logic [4:0] bfly;
    logic       issue_vld;
    logic [4:0] tw_addr;
    logic       tw_vld;
    logic       tw_one;
    logic       tw_negj;
    logic       stage_last;
    logic       done;

    modport master (
        output start, valid, abort,
        input  busy, stage, bfly, issue_vld, tw_addr,
        input  tw_vld, tw_one, tw_negj, stage_last, done
    );

    modport slave (
        input  start, valid, abort,
        output busy, stage, bfly, issue_vld, tw_addr,
        output tw_vld, tw_one, tw_negj, stage_last, done
    );

endinterface

// File: rtl/fft_tw_pipe.sv
// DLY-deep shift register of twiddle entries; flush clears
// every stage so aborted work never reaches the butterfly.
module fft_tw_pipe
    import fft_pkg::*;
#(
    parameter int DLY = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_flush,
    input  tw_ent_t i_d,
    output tw_ent_t o_q
);

    tw_ent_t r_q [DLY];

    // Shift every cycle; bubbles enter as all-zero entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) r_q[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DLY; i++) r_q[i] <= '0;
        end else begin
            r_q[0] <= i_d;
            for (int i = 1; i < DLY; i++) r_q[i] <= r_q[i-1];
        end
    end

    assign o_q = r_q[DLY-1];

endmodule

// File: rtl/fft_twiddle_sched.sv
// Butterfly/twiddle sequencer: walks 6 stages x 32 butterflies
// and emits twiddle address/flags aligned to bank read data.
module fft_twiddle_sched
    import fft_pkg::*;
#(
    parameter int LOG2N = 6,
    parameter int DLY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    fft_twiddle_sched_if.slave  bus
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_stage;
    logic [4:0] r_bfly;
    logic       w_issue;
    logic       w_s_end;
    logic       w_b_end;
    logic       w_done;
    tw_ent_t    w_ent;
    tw_ent_t    w_out;

    assign w_s_end = (r_stage == 3'(LOG2N - 1));
    assign w_b_end = (r_bfly == 5'(NBFLY - 1));
    assign w_done  = w_out.vld & w_out.last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and issue decision; abort overrides all.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
            end
            S_RUN: begin
                w_issue = bus.valid;
                if (bus.valid && w_s_end && w_b_end)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end

    // Stage/butterfly counters; they wrap to 0 after the last issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
            r_bfly  <= '0;
        end else if (bus.abort) begin
            r_stage <= '0;
            r_bfly  <= '0;
        end else if (w_issue) begin
            if (w_b_end) begin
                r_bfly  <= '0;
                r_stage <= w_s_end ? 3'd0 : r_stage + 3'd1;
            end else begin
                r_bfly  <= r_bfly + 5'd1;
            end
        end
    end

    // Twiddle entry for the butterfly issued this cycle.
    always_comb begin
        w_ent = '0;
        if (w_issue) begin
            w_ent.vld  = 1'b1;
            w_ent.e    = tw_exp(r_stage, r_bfly);
            w_ent.one  = (w_ent.e == '0);
            w_ent.negj = (w_ent.e == E_NEGJ);
            w_ent.s5   = w_s_end;
            w_ent.last = w_s_end & w_b_end;
        end
    end

    fft_tw_pipe #(
        .DLY (DLY)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.abort),
        .i_d     (w_ent),
        .o_q     (w_out)
    );

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.stage      = r_stage;
    assign bus.bfly       = r_bfly;
    assign bus.issue_vld  = w_issue;
    assign bus.tw_vld     = w_out.vld;
    assign bus.tw_addr    = w_out.e & {TW_W{w_out.vld}};
    assign bus.tw_one     = w_out.one & w_out.vld;
    assign bus.tw_negj    = w_out.negj & w_out.vld;
    assign bus.stage_last = w_out.s5 & w_out.vld;
    assign bus.done       = w_done;

endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Directed self-checking bench for fft_twiddle_sched
// (one instance with DLY=1, one with DLY=3).
module tb_fft_twiddle_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [4:0] obs_addr [192];
    logic       obs_one  [192];
    logic       obs_negj [192];
    logic       obs_last [192];

    fft_twiddle_sched_if if1();
    fft_twiddle_sched_if if3();

    fft_twiddle_sched #(.LOG2N(6), .DLY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    fft_twiddle_sched #(.LOG2N(6), .DLY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    always #5 clk = ~clk;

    // Step to 1 time unit after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] v1, v3;
        if1.start = 0; if1.valid = 0; if1.abort = 0;
        if3.start = 0; if3.valid = 0; if3.abort = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #2;
        v1 = {if1.busy, if1.issue_vld, if1.tw_vld, if1.tw_one,
              if1.tw_negj, if1.stage_last, if1.done, if1.tw_addr,
              if1.stage, if1.bfly};
        v3 = {if3.busy, if3.issue_vld, if3.tw_vld, if3.tw_one,
              if3.tw_negj, if3.stage_last, if3.done, if3.tw_addr,
              if3.stage, if3.bfly};
        n_chk++;
        if (v1 !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_dly1: got %h expected 0", v1);
        end
        n_chk++;
        if (v3 !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_dly3: got %h expected 0", v3);
        end
        nxt();
        rst = 0;
    endtask

    task automatic test_frame();
        int k, e, vfirst, vlast, vcnt, dcnt, dcyc, bfirst, blast;
        int bad_iss, bad_tw;
        vfirst = -1; vlast = -1; vcnt = 0; dcnt = 0; dcyc = -1;
        bfirst = -1; blast = -1; bad_iss = 0; bad_tw = 0;
        nxt();
        if1.start = 1; if1.valid = 0;
        #1;
        n_chk++;
        if (if1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_idle_busy: got %b expected 0", if1.busy);
        end
        for (int c = 1; c <= 200; c++) begin
            nxt();
            if1.start = 0; if1.valid = 1;
            #1;
            if (c <= 192) begin
                k = c - 1;
                if (if1.issue_vld !== 1'b1 || if1.stage !== 3'(k / 32) ||
                    if1.bfly !== 5'(k % 32)) bad_iss++;
            end else if (if1.issue_vld !== 1'b0) bad_iss++;
            if (if1.tw_vld === 1'b1) begin
                vcnt++;
                if (vfirst < 0) vfirst = c;
                vlast = c;
                k = c - 2;
                if (k >= 0 && k < 192) begin
                    obs_addr[k] = if1.tw_addr;
                    obs_one[k]  = if1.tw_one;
                    obs_negj[k] = if1.tw_negj;
                    obs_last[k] = if1.stage_last;
                    e = ((k % 32) << (k / 32)) & 31;
                    if (if1.tw_addr !== 5'(e) || if1.tw_one !== (e == 0) ||
                        if1.tw_negj !== (e == 16) ||
                        if1.stage_last !== (k >= 160)) bad_tw++;
                end else bad_tw++;
            end else if ({if1.tw_addr, if1.tw_one, if1.tw_negj,
                          if1.stage_last} !== 8'd0) bad_tw++;
            if (if1.done === 1'b1) begin dcnt++; dcyc = c; end
            if (if1.busy === 1'b1) begin
                if (bfirst < 0) bfirst = c;
                blast = c;
            end
        end
        n_chk++;
        if (bad_iss !== 0) begin
            n_fail++;
            $display("FAIL frame_issue: got %0d bad cycles expected 0", bad_iss);
        end
        n_chk++;
        if (bad_tw !== 0) begin
            n_fail++;
            $display("FAIL frame_twiddle: got %0d bad cycles expected 0", bad_tw);
        end
        n_chk++;
        if (vfirst !== 2 || vlast !== 193 || vcnt !== 192) begin
            n_fail++;
            $display("FAIL frame_tw_vld: got %0d..%0d n=%0d expected 2..193 n=192",
                     vfirst, vlast, vcnt);
        end
        n_chk++;
        if (dcnt !== 1 || dcyc !== 193) begin
            n_fail++;
            $display("FAIL frame_done: got n=%0d at %0d expected n=1 at 193",
                     dcnt, dcyc);
        end
        n_chk++;
        if (bfirst !== 1 || blast !== 193) begin
            n_fail++;
            $display("FAIL frame_busy: got %0d..%0d expected 1..193",
                     bfirst, blast);
        end
    endtask

    task automatic test_spot();
        int bad;
        n_chk++;
        if (obs_addr[37] !== 5'd10) begin
            n_fail++;
            $display("FAIL spot_s1b5: got %0d expected 10", obs_addr[37]);
        end
        n_chk++;
        if (obs_addr[77] !== 5'd20) begin
            n_fail++;
            $display("FAIL spot_s2b13: got %0d expected 20", obs_addr[77]);
        end
        n_chk++;
        if (obs_addr[16] !== 5'd16 || obs_negj[16] !== 1'b1 ||
            obs_one[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL spot_s0b16: got addr=%0d negj=%b one=%b expected 16 1 0",
                     obs_addr[16], obs_negj[16], obs_one[16]);
        end
        n_chk++;
        if (obs_one[0] !== 1'b1 || obs_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL spot_s0b0: got one=%b last=%b expected 1 0",
                     obs_one[0], obs_last[0]);
        end
        bad = 0;
        for (int k = 160; k < 192; k++)
            if (obs_addr[k] !== 5'd0 || obs_one[k] !== 1'b1 ||
                obs_last[k] !== 1'b1 || obs_negj[k] !== 1'b0) bad++;
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL spot_s5: got %0d bad entries expected 0", bad);
        end
    endtask

    task automatic test_valid_toggle();
        int iss, last_iss, bad_v, bad_hold, dcyc, dcnt;
        logic [2:0] ps;
        logic [4:0] pb;
        iss = 0; last_iss = -1; bad_v = 0; bad_hold = 0; dcyc = -1; dcnt = 0;
        ps = '0; pb = '0;
        nxt();
        if1.start = 1; if1.valid = 0;
        for (int c = 1; c <= 390; c++) begin
            nxt();
            if1.start = 0;
            if1.valid = (c % 2 == 1);
            #1;
            if (if1.issue_vld === 1'b1) begin iss++; last_iss = c; end
            if (if1.tw_vld !== ((c % 2 == 0) && c >= 2 && c <= 384)) bad_v++;
            if (c % 2 == 1 && c >= 3 && c <= 383 &&
                (if1.stage !== ps || if1.bfly !== pb)) bad_hold++;
            ps = if1.stage; pb = if1.bfly;
            if (if1.done === 1'b1) begin dcnt++; dcyc = c; end
        end
        if1.valid = 1;
        n_chk++;
        if (iss !== 192 || last_iss !== 383) begin
            n_fail++;
            $display("FAIL toggle_issues: got n=%0d last=%0d expected n=192 last=383",
                     iss, last_iss);
        end
        n_chk++;
        if (bad_v !== 0) begin
            n_fail++;
            $display("FAIL toggle_bubbles: got %0d bad cycles expected 0", bad_v);
        end
        n_chk++;
        if (bad_hold !== 0) begin
            n_fail++;
            $display("FAIL toggle_hold: got %0d bad stalls expected 0", bad_hold);
        end
        n_chk++;
        if (dcnt !== 1 || dcyc !== 384) begin
            n_fail++;
            $display("FAIL toggle_done: got n=%0d at %0d expected n=1 at 384",
                     dcnt, dcyc);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, dcnt;
        logic b194, b195;
        d1 = -1; d2 = -1; dcnt = 0; b194 = 1'bx; b195 = 1'bx;
        nxt();
        if1.start = 1; if1.valid = 1;
        for (int c = 1; c <= 395; c++) begin
            nxt();
            if1.start = (c >= 50 && c <= 60) || c == 193 || c == 194;
            #1;
            if (if1.done === 1'b1) begin
                dcnt++;
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
            if (c == 194) b194 = if1.busy;
            if (c == 195) b195 = if1.busy;
        end
        if1.start = 0;
        n_chk++;
        if (dcnt !== 2 || d1 !== 193 || d2 !== 387) begin
            n_fail++;
            $display("FAIL b2b_done: got n=%0d at %0d,%0d expected n=2 at 193,387",
                     dcnt, d1, d2);
        end
        n_chk++;
        if (b194 !== 1'b0 || b195 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy %b,%b expected 0,1", b194, b195);
        end
    endtask

    task automatic test_dly3_frame();
        int vfirst, vlast, vcnt, dcnt, dcyc;
        logic b196;
        vfirst = -1; vlast = -1; vcnt = 0; dcnt = 0; dcyc = -1; b196 = 1'bx;
        nxt();
        if3.start = 1; if3.valid = 1;
        for (int c = 1; c <= 200; c++) begin
            nxt();
            if3.start = (c >= 2 && c <= 195);
            #1;
            if (if3.tw_vld === 1'b1) begin
                vcnt++;
                if (vfirst < 0) vfirst = c;
                vlast = c;
            end
            if (if3.done === 1'b1) begin dcnt++; dcyc = c; end
            if (c == 196) b196 = if3.busy;
        end
        n_chk++;
        if (vfirst !== 4 || vlast !== 195 || vcnt !== 192) begin
            n_fail++;
            $display("FAIL dly3_tw_vld: got %0d..%0d n=%0d expected 4..195 n=192",
                     vfirst, vlast, vcnt);
        end
        n_chk++;
        if (dcnt !== 1 || dcyc !== 195 || b196 !== 1'b0) begin
            n_fail++;
            $display("FAIL dly3_done: got n=%0d at %0d busy196=%b expected n=1 at 195 busy 0",
                     dcnt, dcyc, b196);
        end
    endtask

    task automatic test_abort();
        int bad_vld, dcnt;
        logic ok117, ok118, ok119, ok123;
        bad_vld = 0; dcnt = 0;
        ok117 = 0; ok118 = 0; ok119 = 0; ok123 = 0;
        nxt();
        if3.start = 1; if3.valid = 1;
        for (int c = 1; c <= 130; c++) begin
            nxt();
            if3.abort = (c == 117) || (c == 122);
            if3.start = (c == 118);
            #1;
            if (c == 117)
                ok117 = (if3.stage === 3'd3 && if3.bfly === 5'd20 &&
                         if3.issue_vld === 1'b1);
            if (c == 118)
                ok118 = (if3.busy === 1'b0 && if3.stage === 3'd0 &&
                         if3.bfly === 5'd0);
            if (c == 119)
                ok119 = (if3.busy === 1'b1 && if3.issue_vld === 1'b1 &&
                         if3.bfly === 5'd0);
            if (c == 123)
                ok123 = (if3.busy === 1'b0 && if3.tw_vld === 1'b0);
            if (c >= 118 && c <= 121 && if3.tw_vld !== 1'b0) bad_vld++;
            if (if3.done !== 1'b0) dcnt++;
        end
        if3.abort = 0; if3.start = 0;
        n_chk++;
        if (!ok117) begin
            n_fail++;
            $display("FAIL abort_point: got s=%0d b=%0d expected s=3 b=20 issuing",
                     if3.stage, if3.bfly);
        end
        n_chk++;
        if (!(ok118 && ok119 && ok123)) begin
            n_fail++;
            $display("FAIL abort_state: got checks %b%b%b expected 111",
                     ok118, ok119, ok123);
        end
        n_chk++;
        if (bad_vld !== 0 || dcnt !== 0) begin
            n_fail++;
            $display("FAIL abort_flush: got tw_vld=%0d done=%0d expected 0 0",
                     bad_vld, dcnt);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [21:0] v;
        logic at_pt;
        int iss, dcyc;
        at_pt = 0; iss = 0; dcyc = -1;
        nxt();
        if1.start = 1; if1.valid = 1;
        for (int c = 1; c <= 72; c++) begin
            nxt();
            if1.start = 0;
            #1;
            if (c == 72) at_pt = (if1.stage === 3'd2 && if1.bfly === 5'd7);
        end
        #2;
        rst = 1;
        #1;
        v = {if1.busy, if1.issue_vld, if1.tw_vld, if1.tw_one,
             if1.tw_negj, if1.stage_last, if1.done, if1.tw_addr,
             if1.stage, if1.bfly};
        n_chk++;
        if (!at_pt || v !== 22'd0) begin
            n_fail++;
            $display("FAIL rst_mid_run: got at_pt=%b outs=%h expected 1 0", at_pt, v);
        end
        nxt();
        rst = 0;
        nxt();
        if1.start = 1;
        for (int c = 1; c <= 200; c++) begin
            nxt();
            if1.start = 0;
            #1;
            if (if1.issue_vld === 1'b1) iss++;
            if (if1.done === 1'b1) dcyc = c;
        end
        n_chk++;
        if (iss !== 192 || dcyc !== 193) begin
            n_fail++;
            $display("FAIL rst_fresh_frame: got n=%0d done=%0d expected 192 193",
                     iss, dcyc);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_spot();
        test_valid_toggle();
        test_back_to_back();
        test_dly3_frame();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_twiddle_sched.md
Name: fft_twiddle_sched

Overview:
Butterfly/twiddle sequencer for the 64-point radix-2 in-place DIF FFT, one butterfly issued per cycle.
- Walks 6 stages x 32 butterflies per frame.
- Drives the twiddle ROM address and multiplier-bypass flags.
- Delays those outputs through a configurable pipeline so they line up with bank read data at the butterfly input.
- Sits beside the bank/address control block and is started and stalled by the same start/valid pair.

Parameters:
- LOG2N, 6, log2 of FFT length. Fixed at 6 for this design; 32 butterflies per stage.
- DLY, 1, pipeline depth from issue to twiddle outputs. Legal range 1..4; must match bank read latency.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  frame start pulse; honoured only in IDLE
- valid  in  1  advance enable; 0 = stall, no issue this cycle
- abort  in  1  synchronous abort to IDLE; flushes pipeline
- busy  out  1  high from RUN entry until done cycle inclusive
- stage  out  3  current issue stage 0..5 (undelayed)
- bfly  out  5  current issue butterfly 0..31 (undelayed)
- issue_vld  out  1  a butterfly issues this cycle (RUN & valid)
- tw_addr  out  5  twiddle ROM address e, delayed DLY
- tw_vld  out  1  tw_addr valid, delayed DLY
- tw_one  out  1  e==0, multiplier bypass (W=1), delayed DLY
- tw_negj  out  1  e==16, W=-j swap/negate, delayed DLY
- stage_last  out  1  delayed entry is from stage 5
- done  out  1  one-cycle pulse coincident with last tw_vld of frame

Behaviour:
- Reset (async, rst=1): FSM=IDLE; stage=0, bfly=0; all pipeline regs 0. Therefore busy, issue_vld, tw_vld, tw_one, tw_negj, stage_last, done, tw_addr are all 0.
- FSM states:
  - IDLE -> RUN when start=1 (registered). stage=0, bfly=0 in the first RUN cycle.
  - RUN:
    - issue_vld = valid.
    - On issue: bfly++. At bfly==31, bfly->0 and stage++.
    - At stage==5 and bfly==31 with issue -> DRAIN.
    - valid=0 holds stage and bfly; no issue.
  - DRAIN: no issue. Stays until the last-flagged entry leaves the pipeline (done cycle), then -> IDLE.
  - abort=1 in any state -> IDLE next cycle; counters 0; all pipeline valid/flag bits cleared next cycle; done not pulsed. abort has priority over start.
- start outside IDLE is ignored. start and abort together -> abort wins.
- Twiddle arithmetic at issue, for stage s and butterfly b:
  - j = b & ((32>>s)-1)
  - e = (j << s) mod 32, width 5
  - W = W64^e
  - tw_one = (e==0); tw_negj = (e==16)
- Pipeline:
  - DLY-deep shift of {vld, e, one, negj, s==5, last}.
  - Shifts every cycle regardless of valid; stall cycles inject vld=0 bubbles.
  - last = issue of (5,31).
  - Flag outputs are ANDed with the delayed vld, so they are 0 on bubbles.
- done = delayed vld & last.
- busy = (state != IDLE).
- Latency, no stalls:
  - start sampled at cycle 0.
  - Issues occupy cycles 1..192.
  - tw_vld high cycles 1+DLY..192+DLY.
  - done at 192+DLY; busy falls at 193+DLY.
- Next frame: start is accepted in the cycle after done. No overlap of frames.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=64, LOG2N=6, NBFLY=32, TW_W=5
  - State encoding: IDLE/RUN/DRAIN
  - E_NEGJ=16
- One natural sub-module: fft_tw_pipe, a DLY-deep valid/flag shift register with synchronous flush.
- FSM, counters and e computation stay in the top module.

Test Plan:
- Reset mid-RUN (rst pulse at stage 2, bfly 7) -> all outputs 0 immediately, state IDLE; a fresh start runs a full 192-issue frame.
- start, valid=1 continuously, DLY=1 -> tw_vld cycles 2..193; done at cycle 193; busy cycles 1..193.
- Spot values:
  - (s=1, b=5) -> tw_addr=10
  - (s=2, b=13) -> tw_addr=20
  - (s=0, b=16) -> tw_addr=16, tw_negj=1
  - any s=5 -> tw_addr=0, tw_one=1, stage_last=1
- valid toggling 1,0,1,0 -> 192 issues over 384 cycles; tw_vld bubbles mirror valid delayed by DLY; counters hold on stalls.
- abort at stage 3, bfly 20 with DLY=3 -> no tw_vld after the next cycle; done never pulses; busy 0 next cycle; start in the following cycle accepted.
- start asserted during RUN and DRAIN -> ignored; exactly one done per frame.
